// File: rtl/l15_req_arbiter_if.sv
// Core-side request/return bundle shared between the requesters and the L15 arbiter.
// master drives requests and L15 responses, slave is the arbiter.
interface l15_req_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2,
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req_val_i;
  logic [NUM_REQ*5-1:0]      req_rqtype_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ack_o;
  logic                      l15_val_o;
  logic [4:0]                l15_rqtype_o;
  logic [ADDR_W-1:0]         l15_address_o;
  logic [DATA_W-1:0]         l15_data_o;
  logic [IDX_W-1:0]          l15_threadid_o;
  logic                      l15_header_ack_i;
  logic                      l15_rtrn_val_i;
  logic [IDX_W-1:0]          l15_rtrn_threadid_i;
  logic [NUM_REQ-1:0]        rtrn_val_o;
  logic [NUM_REQ-1:0]        outst_full_o;

  modport slave (
    input  req_val_i,
    input  req_rqtype_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ack_o,
    output l15_val_o,
    output l15_rqtype_o,
    output l15_address_o,
    output l15_data_o,
    output l15_threadid_o,
    input  l15_header_ack_i,
    input  l15_rtrn_val_i,
    input  l15_rtrn_threadid_i,
    output rtrn_val_o,
    output outst_full_o
  );

  modport master (
    output req_val_i,
    output req_rqtype_i,
    output req_addr_i,
    output req_data_i,
    input  req_ack_o,
    input  l15_val_o,
    input  l15_rqtype_o,
    input  l15_address_o,
    input  l15_data_o,
    input  l15_threadid_o,
    output l15_header_ack_i,
    output l15_rtrn_val_i,
    output l15_rtrn_threadid_i,
    input  rtrn_val_o,
    input  outst_full_o
  );
endinterface

// File: rtl/l15_req_arbiter.sv
// Round-robin arbiter sharing one L15 request port, with per-requester outstanding limits.
// Optional macro L15_ARB_FIXPRIO0_EN: requester 0 always wins when eligible.
module l15_req_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int IDX_W     = 2,
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 64
) (
  input logic             clk_i,
  input logic             rstn_i,
  l15_req_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_idx;
  logic                r_val;
  logic [4:0]          r_rqtype;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt [NUM_REQ];

  logic [NUM_REQ-1:0]  w_full;
  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_ack;
  logic [NUM_REQ-1:0]  w_rtrn;
  logic [NUM_REQ-1:0]  w_dec;
  logic [IDX_W-1:0]    w_cand [NUM_REQ];
  logic                w_any;
  logic [IDX_W-1:0]    w_pick;
  logic [IDX_W-1:0]    w_next_ptr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_full[i] = (r_cnt[i] == CNT_W'(MAX_OUTST));
    end
    w_elig = bus.req_val_i & ~w_full;
  end

  // Scan starting at the pointer; full requesters are simply not eligible.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand[k] = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_elig[w_cand[k]]) begin
        w_any  = 1'b1;
        w_pick = w_cand[k];
      end
    end
`ifdef L15_ARB_FIXPRIO0_EN
    if (w_elig[0]) begin
      w_any  = 1'b1;
      w_pick = '0;
    end
`endif
  end

  assign w_next_ptr = (r_idx == IDX_W'(NUM_REQ - 1)) ?
                      '0 : r_idx + 1'b1;

  // Ack is combinational so the requester can drop valid before IDLE re-arbitrates.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ack[i]  = rstn_i && (r_state == SEND) &&
                  bus.l15_header_ack_i && (r_idx == IDX_W'(i));
      w_rtrn[i] = bus.l15_rtrn_val_i &&
                  (bus.l15_rtrn_threadid_i == IDX_W'(i));
      w_dec[i]  = w_rtrn[i] && (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_val    <= 1'b0;
      r_rqtype <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= SEND;
            r_val    <= 1'b1;
            r_idx    <= w_pick;
            r_rqtype <= bus.req_rqtype_i[int'(w_pick)*5 +: 5];
            r_addr   <= bus.req_addr_i[int'(w_pick)*ADDR_W +: ADDR_W];
            r_data   <= bus.req_data_i[int'(w_pick)*DATA_W +: DATA_W];
          end
        end
        SEND: begin
          if (bus.l15_header_ack_i) begin
            r_state <= IDLE;
            r_val   <= 1'b0;
`ifdef L15_ARB_FIXPRIO0_EN
            if (r_idx != '0) begin
              r_rr_ptr <= w_next_ptr;
            end
`else
            r_rr_ptr <= w_next_ptr;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant and return in the same cycle cancel; returns at zero are dropped.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rstn_i) begin
        r_cnt[i] <= '0;
      end else if (w_ack[i] && !w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end else if (!w_ack[i] && w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  assign bus.req_ack_o      = w_ack;
  assign bus.l15_val_o      = r_val;
  assign bus.l15_rqtype_o   = r_rqtype;
  assign bus.l15_address_o  = r_addr;
  assign bus.l15_data_o     = r_data;
  assign bus.l15_threadid_o = r_idx;
  assign bus.rtrn_val_o     = w_rtrn;
  assign bus.outst_full_o   = w_full;
endmodule

// File: tb/tb_l15_req_arbiter.sv
// Directed bench for l15_req_arbiter: grants, round-robin, limits, returns, reset.
// Build with L15_ARB_FIXPRIO0_EN defined to exercise fixed priority for requester 0.
module tb_l15_req_arbiter;
  localparam int NR = 3;
  localparam int IW = 2;
  localparam int AW = 40;
  localparam int DW = 64;

  logic clk_i;
  logic rstn_i;
  int   errors;
  int   checks;

  l15_req_arbiter_if #(
    .NUM_REQ(NR), .IDX_W(IW), .ADDR_W(AW), .DATA_W(DW)
  ) bus ();

  l15_req_arbiter #(
    .NUM_REQ(NR), .IDX_W(IW), .MAX_OUTST(4),
    .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [AW-1:0] addr_of(int i);
    return 40'h80_0000_0000 | (AW'(i) << 12);
  endfunction

  function automatic logic [DW-1:0] data_of(int i);
    return 64'hD0D0_0000_0000_0000 | DW'(i + 1);
  endfunction

  function automatic logic [4:0] rq_of(int i);
    return 5'(3 * i + 1);
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_payloads();
    for (int i = 0; i < NR; i++) begin
      bus.req_addr_i[i*AW +: AW] = addr_of(i);
      bus.req_data_i[i*DW +: DW] = data_of(i);
      bus.req_rqtype_i[i*5 +: 5] = rq_of(i);
    end
  endtask

  task automatic do_reset();
    rstn_i                  = 1'b0;
    bus.req_val_i           = '0;
    bus.l15_header_ack_i    = 1'b0;
    bus.l15_rtrn_val_i      = 1'b0;
    bus.l15_rtrn_threadid_i = '0;
    set_payloads();
    cyc();
    cyc();
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_val got=%b exp=0", bus.l15_val_o);
    end
    checks++;
    if (bus.l15_threadid_o !== 2'd0 || bus.l15_address_o !== '0 ||
        bus.l15_rqtype_o !== '0 || bus.l15_data_o !== '0) begin
      errors++;
      $display("FAIL reset_regs tid=%0d addr=%h rq=%h data=%h exp=0",
               bus.l15_threadid_o, bus.l15_address_o,
               bus.l15_rqtype_o, bus.l15_data_o);
    end
    checks++;
    if (bus.req_ack_o !== 3'b000 || bus.outst_full_o !== 3'b000) begin
      errors++;
      $display("FAIL reset_ack_full ack=%b full=%b exp=000/000",
               bus.req_ack_o, bus.outst_full_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_rqtype_i[5 +: 5] = 5'h0;
    bus.req_val_i = 3'b010;
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got=%b exp=0", bus.l15_val_o);
    end
    cyc();
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b1 || bus.l15_threadid_o !== 2'd1 ||
        bus.l15_address_o !== 40'h80_0000_1000 ||
        bus.l15_rqtype_o !== 5'h0) begin
      errors++;
      $display("FAIL single_send val=%b tid=%0d addr=%h rq=%h exp=1/1/8000001000/0",
               bus.l15_val_o, bus.l15_threadid_o,
               bus.l15_address_o, bus.l15_rqtype_o);
    end
    cyc();
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b1 || bus.req_ack_o !== 3'b000) begin
      errors++;
      $display("FAIL single_hold val=%b ack=%b exp=1/000",
               bus.l15_val_o, bus.req_ack_o);
    end
    cyc();
    bus.l15_header_ack_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ack_o !== 3'b010) begin
      errors++;
      $display("FAIL single_ack got=%b exp=010", bus.req_ack_o);
    end
    cyc();
    bus.l15_header_ack_i = 1'b0;
    bus.req_val_i = 3'b000;
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b0 || bus.req_ack_o !== 3'b000) begin
      errors++;
      $display("FAIL single_done val=%b ack=%b exp=0/000",
               bus.l15_val_o, bus.req_ack_o);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    bus.req_val_i = 3'b111;
    bus.l15_header_ack_i = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp = g % NR;
      cyc();
      #1;
      checks++;
      if (bus.l15_val_o !== 1'b1 || bus.l15_threadid_o !== IW'(exp) ||
          bus.req_ack_o !== 3'(1 << exp)) begin
        errors++;
        $display("FAIL rr_grant%0d val=%b tid=%0d ack=%b exp tid=%0d",
                 g, bus.l15_val_o, bus.l15_threadid_o, bus.req_ack_o, exp);
      end
      checks++;
      if (bus.l15_address_o !== addr_of(exp) ||
          bus.l15_data_o !== data_of(exp) ||
          bus.l15_rqtype_o !== rq_of(exp)) begin
        errors++;
        $display("FAIL rr_payload%0d addr=%h data=%h rq=%h exp=%h/%h/%h",
                 g, bus.l15_address_o, bus.l15_data_o, bus.l15_rqtype_o,
                 addr_of(exp), data_of(exp), rq_of(exp));
      end
      cyc();
      #1;
      checks++;
      if (bus.req_ack_o !== 3'b000 || bus.l15_val_o !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d ack=%b val=%b exp=000/0",
                 g, bus.req_ack_o, bus.l15_val_o);
      end
    end
    bus.req_val_i = '0;
    bus.l15_header_ack_i = 1'b0;
  endtask

  task automatic test_outstanding();
    int seq [5] = '{0, 1, 0, 1, 2};
    do_reset();
    bus.req_val_i = 3'b100;
    bus.l15_header_ack_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      cyc();
      #1;
      checks++;
      if (bus.l15_threadid_o !== 2'd2 || bus.req_ack_o !== 3'b100) begin
        errors++;
        $display("FAIL outst_fill%0d tid=%0d ack=%b exp=2/100",
                 g, bus.l15_threadid_o, bus.req_ack_o);
      end
      cyc();
    end
    #1;
    checks++;
    if (bus.outst_full_o !== 3'b100) begin
      errors++;
      $display("FAIL outst_full got=%b exp=100", bus.outst_full_o);
    end
    bus.req_val_i = 3'b111;
    for (int g = 0; g < 5; g++) begin
      cyc();
      #1;
      checks++;
      if (bus.l15_threadid_o !== IW'(seq[g])) begin
        errors++;
        $display("FAIL outst_skip%0d tid=%0d exp=%0d",
                 g, bus.l15_threadid_o, seq[g]);
      end
      if (g == 3) begin
        bus.l15_rtrn_val_i = 1'b1;
        bus.l15_rtrn_threadid_i = 2'd2;
        #1;
        checks++;
        if (bus.rtrn_val_o !== 3'b100) begin
          errors++;
          $display("FAIL outst_rtrn got=%b exp=100", bus.rtrn_val_o);
        end
        cyc();
        bus.l15_rtrn_val_i = 1'b0;
        #1;
        checks++;
        if (bus.outst_full_o !== 3'b000) begin
          errors++;
          $display("FAIL outst_clear got=%b exp=000", bus.outst_full_o);
        end
      end else begin
        cyc();
      end
    end
    bus.req_val_i = '0;
    bus.l15_header_ack_i = 1'b0;
  endtask

  task automatic test_simul_rtrn();
    do_reset();
    bus.req_val_i = 3'b010;
    bus.l15_header_ack_i = 1'b1;
    for (int g = 0; g < 2; g++) begin
      cyc();
      cyc();
    end
    cyc();
    bus.l15_rtrn_val_i = 1'b1;
    bus.l15_rtrn_threadid_i = 2'd1;
    #1;
    checks++;
    if (bus.req_ack_o !== 3'b010 || bus.rtrn_val_o !== 3'b010) begin
      errors++;
      $display("FAIL simul_both ack=%b rtrn=%b exp=010/010",
               bus.req_ack_o, bus.rtrn_val_o);
    end
    cyc();
    bus.req_val_i = 3'b000;
    bus.l15_rtrn_threadid_i = 2'd3;
    #1;
    checks++;
    if (bus.rtrn_val_o !== 3'b000) begin
      errors++;
      $display("FAIL simul_tid3 got=%b exp=000", bus.rtrn_val_o);
    end
    cyc();
    bus.l15_rtrn_val_i = 1'b0;
    bus.req_val_i = 3'b010;
    cyc();
    cyc();
    #1;
    checks++;
    if (bus.outst_full_o !== 3'b000) begin
      errors++;
      $display("FAIL simul_cnt3 full=%b exp=000", bus.outst_full_o);
    end
    cyc();
    cyc();
    bus.req_val_i = 3'b000;
    #1;
    checks++;
    if (bus.outst_full_o !== 3'b010) begin
      errors++;
      $display("FAIL simul_cnt4 full=%b exp=010", bus.outst_full_o);
    end
    bus.l15_header_ack_i = 1'b0;
  endtask

  task automatic test_zero_return();
    do_reset();
    bus.l15_rtrn_val_i = 1'b1;
    bus.l15_rtrn_threadid_i = 2'd0;
    cyc();
    bus.l15_rtrn_val_i = 1'b0;
    bus.req_val_i = 3'b001;
    bus.l15_header_ack_i = 1'b1;
    for (int g = 0; g < 3; g++) begin
      cyc();
      cyc();
    end
    #1;
    checks++;
    if (bus.outst_full_o !== 3'b000) begin
      errors++;
      $display("FAIL zero_cnt3 full=%b exp=000", bus.outst_full_o);
    end
    cyc();
    cyc();
    bus.req_val_i = 3'b000;
    #1;
    checks++;
    if (bus.outst_full_o !== 3'b001) begin
      errors++;
      $display("FAIL zero_cnt4 full=%b exp=001", bus.outst_full_o);
    end
    bus.l15_header_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_val_i = 3'b001;
    bus.l15_header_ack_i = 1'b1;
    for (int g = 0; g < 3; g++) begin
      cyc();
      cyc();
    end
    bus.l15_header_ack_i = 1'b0;
    cyc();
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b1 || bus.l15_threadid_o !== 2'd0) begin
      errors++;
      $display("FAIL rmid_send val=%b tid=%0d exp=1/0",
               bus.l15_val_o, bus.l15_threadid_o);
    end
    rstn_i = 1'b0;
    bus.l15_rtrn_val_i = 1'b1;
    bus.l15_rtrn_threadid_i = 2'd0;
    cyc();
    rstn_i = 1'b1;
    bus.l15_rtrn_val_i = 1'b0;
    bus.req_val_i = 3'b000;
    bus.l15_header_ack_i = 1'b1;
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b0 || bus.req_ack_o !== 3'b000 ||
        bus.outst_full_o !== 3'b000) begin
      errors++;
      $display("FAIL rmid_after val=%b ack=%b full=%b exp=0/000/000",
               bus.l15_val_o, bus.req_ack_o, bus.outst_full_o);
    end
    bus.req_val_i = 3'b001;
    cyc();
    cyc();
    #1;
    checks++;
    if (bus.outst_full_o !== 3'b000) begin
      errors++;
      $display("FAIL rmid_cnt1 full=%b exp=000", bus.outst_full_o);
    end
    for (int g = 0; g < 3; g++) begin
      cyc();
      cyc();
    end
    bus.req_val_i = 3'b000;
    #1;
    checks++;
    if (bus.outst_full_o !== 3'b001) begin
      errors++;
      $display("FAIL rmid_cnt4 full=%b exp=001", bus.outst_full_o);
    end
    bus.l15_header_ack_i = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    bus.req_val_i = 3'b100;
    cyc();
    bus.req_val_i = 3'b000;
    cyc();
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b1 || bus.l15_threadid_o !== 2'd2 ||
        bus.l15_address_o !== addr_of(2)) begin
      errors++;
      $display("FAIL drop_hold val=%b tid=%0d addr=%h exp=1/2/%h",
               bus.l15_val_o, bus.l15_threadid_o,
               bus.l15_address_o, addr_of(2));
    end
    bus.l15_header_ack_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ack_o !== 3'b100) begin
      errors++;
      $display("FAIL drop_ack got=%b exp=100", bus.req_ack_o);
    end
    cyc();
    bus.l15_header_ack_i = 1'b0;
    #1;
    checks++;
    if (bus.l15_val_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_done got=%b exp=0", bus.l15_val_o);
    end
  endtask

`ifdef L15_ARB_FIXPRIO0_EN
  task automatic test_fixprio();
    int seq [8] = '{0, 0, 0, 0, 1, 2, 1, 2};
    do_reset();
    bus.req_val_i = 3'b111;
    bus.l15_header_ack_i = 1'b1;
    for (int g = 0; g < 8; g++) begin
      cyc();
      #1;
      checks++;
      if (bus.l15_threadid_o !== IW'(seq[g])) begin
        errors++;
        $display("FAIL fixprio%0d tid=%0d exp=%0d",
                 g, bus.l15_threadid_o, seq[g]);
      end
      cyc();
    end
    bus.req_val_i = '0;
    bus.l15_header_ack_i = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
`ifdef L15_ARB_FIXPRIO0_EN
    test_fixprio();
`else
    test_round_robin();
    test_outstanding();
`endif
    test_simul_rtrn();
    test_zero_return();
    test_reset_mid();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
- Shares the single L1.5 request/return port of a tile between NUM_REQ core-side requesters (e.g. 0=icache, 1=dcache, 2=vector/PTW).
- Picks one requester by round-robin and holds its request stable on the L15 port until the L15 accepts it.
- Tags each request with the requester index in threadid and routes the L15 return back to that requester.
- Limits outstanding transactions per requester.
- Sits between the core memory units and the L15 adapter inside the tile core wrapper.

Parameters:
- NUM_REQ, 3: number of requesters, 2..4.
- IDX_W, 2: index/threadid width; must satisfy 2**IDX_W >= NUM_REQ.
- MAX_OUTST, 4: maximum outstanding requests per requester, 1..15.
- ADDR_W, 40: physical address width.
- DATA_W, 64: request data width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  synchronous active-low reset.
- req_val_i  in  NUM_REQ  per-requester request valid.
- req_rqtype_i  in  NUM_REQ*5  per-requester L15 request type.
- req_addr_i  in  NUM_REQ*ADDR_W  per-requester address.
- req_data_i  in  NUM_REQ*DATA_W  per-requester store data.
- req_ack_o  out  NUM_REQ  one-hot pulse; the request was accepted by L15.
- l15_val_o  out  1  request valid to L15.
- l15_rqtype_o  out  5  selected request type.
- l15_address_o  out  ADDR_W  selected address.
- l15_data_o  out  DATA_W  selected data.
- l15_threadid_o  out  IDX_W  index of the granted requester.
- l15_header_ack_i  in  1  L15 accepted the request.
- l15_rtrn_val_i  in  1  return valid from L15.
- l15_rtrn_threadid_i  in  IDX_W  return owner.
- rtrn_val_o  out  NUM_REQ  return valid, decoded from threadid.
- outst_full_o  out  NUM_REQ  requester at MAX_OUTST.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-low (rstn_i sampled on posedge clk_i).
  - Reset values: state=IDLE, rr_ptr=0, all outstanding counters=0, l15_val_o=0, l15_threadid_o=0, req_ack_o=0, outst_full_o=0.
  - l15_rqtype_o, l15_address_o and l15_data_o reset to 0.
- FSM, two states:
  - IDLE: build eligible[i] = req_val_i[i] & ~outst_full[i]. If any bit is set, pick the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ. Register rqtype/addr/data/index into the output regs and go to SEND. Otherwise stay in IDLE.
  - SEND: l15_val_o=1 and all outputs held constant. When l15_header_ack_i=1: pulse req_ack_o[idx] for that cycle, set rr_ptr=(idx+1) mod NUM_REQ, and go to IDLE.
- Latency and throughput:
  - l15_val_o rises 1 cycle after req_val_i is seen in IDLE.
  - Minimum 2 cycles per request, so peak throughput is 1 request per 2 cycles.
- Requester contract:
  - A requester keeps req_val_i and its payload stable until its req_ack_o.
  - The arbiter never drops or changes a request while in SEND.
- Outstanding counters (per requester, width clog2(MAX_OUTST+1)):
  - +1 on req_ack_o[i]; -1 on rtrn_val_o[i].
  - If both happen in the same cycle, the counter is unchanged.
  - outst_full_o[i] = (cnt==MAX_OUTST), combinational from the counter.
  - A full requester is skipped by the arbiter; the pointer does not stall on it.
- Return routing:
  - rtrn_val_o[i] = l15_rtrn_val_i & (l15_rtrn_threadid_i==i), combinational, zero latency.
  - A threadid >= NUM_REQ produces no rtrn_val_o bit and no counter change.
  - A return to a requester whose counter is 0 is ignored; the counter stays at 0 and never wraps.
- Boundary conditions:
  - A requester dropping req_val_i while in SEND violates the contract. The arbiter still completes the held request.
  - rstn_i=0 in SEND: on the next edge the block is in IDLE with l15_val_o=0 and counters cleared. Returns in flight at reset are ignored.
  - A return and a new grant to the same requester in one cycle are handled as described above (counter unchanged).

Optional Feature:
- L15_ARB_FIXPRIO0_EN:
  - Defined: in IDLE, requester 0 wins whenever it is eligible, regardless of rr_ptr. rr_ptr is updated only on grants to requesters 1..NUM_REQ-1. Intended to give instruction fetch priority.
  - Undefined: pure round-robin, as in Behaviour.

Test Plan:
- Single request: req_val_i=3'b010, addr=40'h80_0000_1000, rqtype=5'h0, no prior grants. l15_val_o=1 in cycle+1 with threadid=1. header_ack held 2 cycles later. req_ack_o=3'b010 for 1 cycle, then l15_val_o=0.
- Round-robin: all three requesters held valid, header_ack always 1. Grant order is 0,1,2,0,1,2, and each req_ack pulse is 2 cycles apart.
- Outstanding limit: MAX_OUTST=4, requester 2 issues 4 requests with no returns. outst_full_o[2]=1 and requester 2 is skipped while requesters 0 and 1 are still granted. One return with threadid=2 clears full and the next grant goes to 2.
- Simultaneous grant and return to requester 1 with cnt=2: cnt stays 2. Return with threadid=3 (NUM_REQ=3): rtrn_val_o=0 and no counters change.
- Reset mid-SEND: rstn_i=0 for 1 cycle while l15_val_o=1 and cnt[0]=3. Next cycle l15_val_o=0, all counters 0, state=IDLE.
- L15_ARB_FIXPRIO0_EN defined, all requesters valid: requester 0 wins every arbitration. With req_val_i[0]=0, requesters 1 and 2 alternate.
